// File: rtl/snitch_vfpr_wb.sv
// -----------------------------------------------------------------------------
// snitch_vfpr_wb
//
// Write-back initiator for the vector FP register file (VFPR). FPU results
// arrive on a valid/ready stream and are buffered in a small input queue. Each
// queued result becomes a TCDM write request toward the VFPR write port. Every
// issued write is tracked until its TCDM response returns. Completion tags are
// then handed out in issue order. A combinational address-hazard check lets the
// operand-read side stall on registers that still have writes pending.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   wb_addr_i/_data_i   destination byte address and result data
//   wb_tag_i            opaque result tag, returned on completion
//   wb_valid_i/ready_o  input handshake (ready = input queue not full)
//   wr_req_o            TCDM request to the VFPR write port
//   wr_rsp_i            TCDM response from the VFPR write port
//   done_tag_o          tag of the oldest acknowledged write
//   done_valid_o/_i     completion handshake
//   chk_addr_i/en_i     up to three operand addresses to test for hazards
//   chk_hit_o           per-operand hazard flag
//   busy_o              queue or tracker holds at least one entry
// -----------------------------------------------------------------------------
package snitch_vfpr_wb_pkg;

  typedef logic [7:0] tag_t;

  typedef enum logic [3:0] {
    AMONone = 4'h0, AMOSwap = 4'h1, AMOAdd  = 4'h2, AMOAnd  = 4'h3,
    AMOOr   = 4'h4, AMOXor  = 4'h5, AMOMax  = 4'h6, AMOMaxu = 4'h7,
    AMOMin  = 4'h8, AMOMinu = 4'h9, AMOLR   = 4'hA, AMOSC   = 4'hB
  } amo_op_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    amo_op_e     amo;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        user;
  } tcdm_req_chan_t;

  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
  } tcdm_req_t;

  typedef struct packed {
    logic [63:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    tcdm_rsp_chan_t p;
    logic           p_valid;
  } tcdm_rsp_t;

endpackage

module snitch_vfpr_wb #(
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned QueueDepth     = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter type tcdm_req_t = snitch_vfpr_wb_pkg::tcdm_req_t,
  parameter type tcdm_rsp_t = snitch_vfpr_wb_pkg::tcdm_rsp_t,
  parameter type tag_t      = snitch_vfpr_wb_pkg::tag_t
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [AddrWidth-1:0]      wb_addr_i,
  input  logic [DataWidth-1:0]      wb_data_i,
  input  tag_t                      wb_tag_i,
  input  logic                      wb_valid_i,
  output logic                      wb_ready_o,
  output tcdm_req_t                 wr_req_o,
  input  tcdm_rsp_t                 wr_rsp_i,
  output tag_t                      done_tag_o,
  output logic                      done_valid_o,
  input  logic                      done_ready_i,
  input  logic [2:0][AddrWidth-1:0] chk_addr_i,
  input  logic [2:0]                chk_en_i,
  output logic [2:0]                chk_hit_o,
  output logic                      busy_o
);

  localparam int unsigned QPtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int unsigned QCntW = $clog2(QueueDepth + 1);
  localparam int unsigned TPtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned TCntW = $clog2(MaxOutstanding + 1);

  // ---------------------------------------------------------------------------
  // Input queue
  // ---------------------------------------------------------------------------
  logic [AddrWidth-1:0]  q_addr_q [QueueDepth];
  logic [DataWidth-1:0]  q_data_q [QueueDepth];
  tag_t                  q_tag_q  [QueueDepth];
  logic [QueueDepth-1:0] q_vld_q, q_vld_d;
  logic [QPtrW-1:0]      q_wptr_q, q_wptr_d, q_rptr_q, q_rptr_d;
  logic [QCntW-1:0]      q_cnt_q, q_cnt_d;
  logic                  q_full, q_empty, q_push, q_pop;

  // ---------------------------------------------------------------------------
  // Outstanding-write tracker
  // ---------------------------------------------------------------------------
  logic [AddrWidth-1:0]      t_addr_q [MaxOutstanding];
  tag_t                      t_tag_q  [MaxOutstanding];
  logic [MaxOutstanding-1:0] t_vld_q, t_vld_d;
  logic [TPtrW-1:0]          t_wptr_q, t_wptr_d, t_rptr_q, t_rptr_d;
  logic [TCntW-1:0]          t_cnt_q, t_cnt_d;
  logic [TCntW-1:0]          acked_cnt_q, acked_cnt_d;
  logic                      t_full, t_empty;

  logic issue_valid, issue_fire, rsp_ok, done_fire;

  assign q_full  = (q_cnt_q == QCntW'(QueueDepth));
  assign q_empty = (q_cnt_q == '0);
  assign t_full  = (t_cnt_q == TCntW'(MaxOutstanding));
  assign t_empty = (t_cnt_q == '0);

  // Ready depends only on current occupancy: a pop in the same cycle does not
  // open a slot for the incoming entry.
  assign wb_ready_o  = !q_full;
  assign q_push      = wb_valid_i && !q_full;

  assign issue_valid = !q_empty && !t_full;
  assign issue_fire  = issue_valid && wr_rsp_i.q_ready;
  assign q_pop       = issue_fire;

  // A response is only legal while some issued write is still unacknowledged.
  // A surplus response is dropped so the counter can never overtake occupancy.
  assign rsp_ok       = wr_rsp_i.p_valid && (acked_cnt_q != t_cnt_q);
  assign done_valid_o = (acked_cnt_q != '0);
  assign done_fire    = done_valid_o && done_ready_i;
  assign done_tag_o   = t_tag_q[t_rptr_q];

  assign busy_o = !q_empty || !t_empty;

  always_comb begin
    wr_req_o         = '0;
    wr_req_o.q_valid = issue_valid;
    wr_req_o.q.addr  = q_addr_q[q_rptr_q];
    wr_req_o.q.data  = q_data_q[q_rptr_q];
    wr_req_o.q.write = 1'b1;
    wr_req_o.q.strb  = '1;
    wr_req_o.q.amo   = snitch_vfpr_wb_pkg::AMONone;
    wr_req_o.q.user  = '0;
  end

  // Next-state for both FIFOs. Valid bits mirror occupancy per slot so the
  // hazard check can scan entries without decoding pointer distances.
  always_comb begin
    q_wptr_d    = q_wptr_q;
    q_rptr_d    = q_rptr_q;
    q_vld_d     = q_vld_q;
    t_wptr_d    = t_wptr_q;
    t_rptr_d    = t_rptr_q;
    t_vld_d     = t_vld_q;
    q_cnt_d     = q_cnt_q + QCntW'(q_push) - QCntW'(q_pop);
    t_cnt_d     = t_cnt_q + TCntW'(issue_fire) - TCntW'(done_fire);
    acked_cnt_d = acked_cnt_q + TCntW'(rsp_ok) - TCntW'(done_fire);

    if (q_push) begin
      q_vld_d[q_wptr_q] = 1'b1;
      q_wptr_d = (q_wptr_q == QPtrW'(QueueDepth - 1)) ? '0 : q_wptr_q + QPtrW'(1);
    end
    if (q_pop) begin
      q_vld_d[q_rptr_q] = 1'b0;
      q_rptr_d = (q_rptr_q == QPtrW'(QueueDepth - 1)) ? '0 : q_rptr_q + QPtrW'(1);
    end
    if (issue_fire) begin
      t_vld_d[t_wptr_q] = 1'b1;
      t_wptr_d = (t_wptr_q == TPtrW'(MaxOutstanding - 1)) ? '0 : t_wptr_q + TPtrW'(1);
    end
    if (done_fire) begin
      t_vld_d[t_rptr_q] = 1'b0;
      t_rptr_d = (t_rptr_q == TPtrW'(MaxOutstanding - 1)) ? '0 : t_rptr_q + TPtrW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_wptr_q    <= '0;
      q_rptr_q    <= '0;
      q_cnt_q     <= '0;
      q_vld_q     <= '0;
      t_wptr_q    <= '0;
      t_rptr_q    <= '0;
      t_cnt_q     <= '0;
      t_vld_q     <= '0;
      acked_cnt_q <= '0;
    end else begin
      q_wptr_q    <= q_wptr_d;
      q_rptr_q    <= q_rptr_d;
      q_cnt_q     <= q_cnt_d;
      q_vld_q     <= q_vld_d;
      t_wptr_q    <= t_wptr_d;
      t_rptr_q    <= t_rptr_d;
      t_cnt_q     <= t_cnt_d;
      t_vld_q     <= t_vld_d;
      acked_cnt_q <= acked_cnt_d;
    end
  end

  // Payload storage needs no reset: the valid bits gate every use of it.
  always_ff @(posedge clk_i) begin
    if (q_push) begin
      q_addr_q[q_wptr_q] <= wb_addr_i;
      q_data_q[q_wptr_q] <= wb_data_i;
      q_tag_q[q_wptr_q]  <= wb_tag_i;
    end
    if (issue_fire) begin
      t_addr_q[t_wptr_q] <= q_addr_q[q_rptr_q];
      t_tag_q[t_wptr_q]  <= q_tag_q[q_rptr_q];
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard check: full-address compare against every live entry. Tracker
  // entries keep hitting until the done handshake retires them.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_chk
    logic hit;
    always_comb begin
      hit = 1'b0;
      for (int j = 0; j < int'(QueueDepth); j++) begin
        if (q_vld_q[j] && (q_addr_q[j] == chk_addr_i[gi])) hit = 1'b1;
      end
      for (int j = 0; j < int'(MaxOutstanding); j++) begin
        if (t_vld_q[j] && (t_addr_q[j] == chk_addr_i[gi])) hit = 1'b1;
      end
    end
    assign chk_hit_o[gi] = chk_en_i[gi] && hit;
  end

  // Response payload carries nothing useful for a write.
  logic unused_rsp;
  assign unused_rsp = ^wr_rsp_i.p;

`ifndef SYNTHESIS
  rsp_without_pending_write : assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(wr_rsp_i.p_valid && (acked_cnt_q == t_cnt_q))
  );
`endif

endmodule

// File: tb/tb_snitch_vfpr_wb.sv
module tb_snitch_vfpr_wb;
  import snitch_vfpr_wb_pkg::*;

  logic             clk;
  logic             rst;
  logic [31:0]      wb_addr;
  logic [63:0]      wb_data;
  tag_t             wb_tag;
  logic             wb_valid;
  logic             wb_ready;
  tcdm_req_t        wr_req;
  tcdm_rsp_t        wr_rsp;
  tag_t             done_tag;
  logic             done_valid;
  logic             done_ready;
  logic [2:0][31:0] chk_addr;
  logic [2:0]       chk_en;
  logic [2:0]       chk_hit;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  snitch_vfpr_wb dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wb_addr_i    (wb_addr),
    .wb_data_i    (wb_data),
    .wb_tag_i     (wb_tag),
    .wb_valid_i   (wb_valid),
    .wb_ready_o   (wb_ready),
    .wr_req_o     (wr_req),
    .wr_rsp_i     (wr_rsp),
    .done_tag_o   (done_tag),
    .done_valid_o (done_valid),
    .done_ready_i (done_ready),
    .chk_addr_i   (chk_addr),
    .chk_en_i     (chk_en),
    .chk_hit_o    (chk_hit),
    .busy_o       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] a, input logic [63:0] d, input int t);
    wb_addr  = a;
    wb_data  = d;
    wb_tag   = tag_t'(t);
    wb_valid = 1'b1;
  endtask

  // Runs with a one-cycle response latency, checking issue addresses
  // (iss_base + 8*k) and completion tags (tag_base + k) in order.
  task automatic drain(input int n_done, input logic [31:0] iss_base,
                       input int tag_base, input int iss_n);
    int   ii = 0;
    int   di = 0;
    logic last_iss = 1'b0;
    logic acc_pend = 1'b0;
    for (int c = 0; c < 60 && di < n_done; c++) begin
      if (acc_pend) wb_valid = 1'b0;
      acc_pend = wb_valid && wb_ready;
      wr_rsp.p_valid = last_iss;
      last_iss = wr_req.q_valid && wr_rsp.q_ready;
      if (last_iss) begin
        check("iss_addr", wr_req.q.addr, iss_base + 32'(8 * ii));
        $display("[TB] issue addr 0x%0h", wr_req.q.addr);
        ii++;
      end
      if (done_valid && done_ready) begin
        check("done_tag", done_tag, tag_t'(tag_base + di));
        $display("[TB] done tag %0d", done_tag);
        di++;
      end
      tick();
    end
    wr_rsp.p_valid = 1'b0;
    check("drain_done_cnt", di, n_done);
    check("drain_iss_cnt", ii, iss_n);
  endtask

  initial begin
    int   k;
    int   n_iss;
    logic last_iss;

    rst        = 1'b1;
    wb_valid   = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
    wb_tag     = '0;
    wr_rsp     = '0;
    wr_rsp.q_ready = 1'b1;
    done_ready = 1'b1;
    chk_addr   = '0;
    chk_en     = 3'b111;

    // Reset state
    #2;
    check("rst_wb_ready", wb_ready, 1'b1);
    check("rst_q_valid", wr_req.q_valid, 1'b0);
    check("rst_done_valid", done_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_chk_hit", chk_hit, 3'b000);
    tick(); tick();
    rst    = 1'b0;
    chk_en = 3'b000;
    tick();

    // Single write
    drive(32'h40, 64'hDEAD_BEEF, 3);
    check("t1_ready", wb_ready, 1'b1);
    tick();
    wb_valid = 1'b0;
    check("t1_q_valid", wr_req.q_valid, 1'b1);
    check("t1_addr", wr_req.q.addr, 32'h40);
    check("t1_data", wr_req.q.data, 64'hDEAD_BEEF);
    check("t1_write", wr_req.q.write, 1'b1);
    check("t1_strb", wr_req.q.strb, 8'hFF);
    check("t1_amo", wr_req.q.amo, AMONone);
    check("t1_user", wr_req.q.user, 1'b0);
    tick();
    check("t1_q_valid_drop", wr_req.q_valid, 1'b0);
    check("t1_done_early", done_valid, 1'b0);
    wr_rsp.p_valid = 1'b1;
    tick();
    wr_rsp.p_valid = 1'b0;
    check("t1_done_valid", done_valid, 1'b1);
    check("t1_done_tag", done_tag, tag_t'(3));
    $display("[TB] single write done tag %0d", done_tag);
    tick();
    check("t1_done_clear", done_valid, 1'b0);
    check("t1_busy", busy, 1'b0);

    // Backpressure: 5 entries offered while q_ready is low
    wr_rsp.q_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h100 + 32'(8 * i), 64'(i), 10 + i);
      check("t2_wb_ready", wb_ready, (i < 4) ? 1'b1 : 1'b0);
      if (i >= 1) begin
        check("t2_q_valid", wr_req.q_valid, 1'b1);
        check("t2_head_stable", wr_req.q.addr, 32'h100);
      end
      tick();
    end
    check("t2_still_full", wb_ready, 1'b0);
    check("t2_head_stable_end", wr_req.q.addr, 32'h100);
    wr_rsp.q_ready = 1'b1;
    drain(5, 32'h100, 10, 5);

    // Tracker full
    done_ready = 1'b0;
    k = 0;
    n_iss = 0;
    last_iss = 1'b0;
    for (int c = 0; c < 12; c++) begin
      wr_rsp.p_valid = last_iss;
      last_iss = wr_req.q_valid && wr_rsp.q_ready;
      if (last_iss) begin
        check("t3_iss_addr", wr_req.q.addr, 32'h200 + 32'(8 * n_iss));
        n_iss++;
      end
      if (k < 6) drive(32'h200 + 32'(8 * k), 64'(k), k);
      else wb_valid = 1'b0;
      if (wb_valid && wb_ready) k++;
      tick();
    end
    wr_rsp.p_valid = 1'b0;
    check("t3_issued", n_iss, 4);
    check("t3_accepted", k, 6);
    check("t3_q_valid_blocked", wr_req.q_valid, 1'b0);
    check("t3_done_pending", done_valid, 1'b1);
    done_ready = 1'b1;
    drain(6, 32'h220, 0, 2);

    // Hazard
    drive(32'h80, 64'h1234, 7);
    chk_addr = {32'h80, 32'h88, 32'h80};
    chk_en   = 3'b011;
    #1;
    check("t4_bus_excluded", chk_hit, 3'b000);
    tick();
    wb_valid = 1'b0;
    check("t4_queued_hit", chk_hit, 3'b001);
    tick();
    check("t4_tracked_hit", chk_hit, 3'b001);
    chk_en = 3'b111;
    #1;
    check("t4_all_en_hit", chk_hit, 3'b101);
    chk_en = 3'b011;
    wr_rsp.p_valid = 1'b1;
    tick();
    wr_rsp.p_valid = 1'b0;
    done_ready = 1'b0;
    check("t4_done_valid", done_valid, 1'b1);
    check("t4_acked_still_hit", chk_hit, 3'b001);
    tick();
    done_ready = 1'b1;
    check("t4_handshake_hit", chk_hit, 3'b001);
    tick();
    check("t4_hit_cleared", chk_hit, 3'b000);
    check("t4_done_clear", done_valid, 1'b0);
    chk_en = 3'b000;

    // Response and done handshake in the same cycle
    drive(32'h300, 64'h5, 20);
    tick();
    drive(32'h308, 64'h6, 21);
    tick();
    wb_valid   = 1'b0;
    done_ready = 1'b0;
    tick();
    wr_rsp.p_valid = 1'b1;
    check("t5_done_early", done_valid, 1'b0);
    tick();
    wr_rsp.p_valid = 1'b1;
    done_ready = 1'b1;
    check("t5_first_valid", done_valid, 1'b1);
    check("t5_first_tag", done_tag, tag_t'(20));
    tick();
    wr_rsp.p_valid = 1'b0;
    check("t5_acked_held", done_valid, 1'b1);
    check("t5_next_tag", done_tag, tag_t'(21));
    tick();
    check("t5_done_clear", done_valid, 1'b0);
    check("t5_busy", busy, 1'b0);

    // Reset mid-flight: 2 queued, 2 outstanding (one acknowledged)
    done_ready = 1'b0;
    drive(32'h400, 64'h0, 30);
    tick();
    drive(32'h408, 64'h1, 31);
    tick();
    drive(32'h410, 64'h2, 32);
    tick();
    drive(32'h418, 64'h3, 33);
    wr_rsp.q_ready = 1'b0;
    wr_rsp.p_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    wr_rsp.p_valid = 1'b0;
    chk_addr = {32'h400, 32'h410, 32'h418};
    chk_en   = 3'b111;
    #1;
    check("t6_pre_busy", busy, 1'b1);
    check("t6_pre_done", done_valid, 1'b1);
    check("t6_pre_q_valid", wr_req.q_valid, 1'b1);
    check("t6_pre_hit", chk_hit, 3'b111);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_wb_ready", wb_ready, 1'b1);
    check("t6_rst_q_valid", wr_req.q_valid, 1'b0);
    check("t6_rst_done", done_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_hit", chk_hit, 3'b000);
    tick();
    rst = 1'b0;
    done_ready = 1'b1;
    wr_rsp.q_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t6_no_completion", done_valid, 1'b0);
      check("t6_no_issue", wr_req.q_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
